// File: rtl/seg_reader.sv
// Seven-segment bus reader: samples the display control bus, waits for a pattern to hold
// steady, decodes it once and hands it off over a valid/ready port. Define SEG_READER_HEX_EN for A..F.
module seg_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] seg_in,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] out_digit,
    output logic       out_dp,
    output logic       out_blank,
    output logic       out_err,
    output logic       overrun
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        LOCKED
    } state_t;

    localparam logic [7:0] LAST = 8'(STABLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [8:0] s_q, s_d;
    logic [7:0] cnt_q, cnt_d;
    logic       ld;

    logic       valid_q, valid_d;
    logic [3:0] digit_q, digit_d;
    logic       dp_q, dp_d;
    logic       blank_q, blank_d;
    logic       err_q, err_d;
    logic       ovr_q, ovr_d;

    logic [3:0] dec_digit;
    logic       dec_blank;
    logic       dec_err;

    // Any change of the bus restarts settling, whatever state we are in.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        ld      = 1'b0;
        if (state_q == IDLE || seg_in != s_q) begin
            s_d     = seg_in;
            cnt_d   = 8'd0;
            state_d = SETTLE;
        end else if (state_q == SETTLE) begin
            if (cnt_q == LAST) begin
                ld      = 1'b1;
                state_d = LOCKED;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        dec_digit = 4'd0;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        if (s_q[8] || s_q[6:0] == 7'h00) begin
            dec_blank = 1'b1;
        end else begin
            case (s_q[6:0])
                7'h3f: dec_digit = 4'd0;
                7'h06: dec_digit = 4'd1;
                7'h5b: dec_digit = 4'd2;
                7'h4f: dec_digit = 4'd3;
                7'h66: dec_digit = 4'd4;
                7'h6d: dec_digit = 4'd5;
                7'h7d: dec_digit = 4'd6;
                7'h07: dec_digit = 4'd7;
                7'h7f: dec_digit = 4'd8;
                7'h6f: dec_digit = 4'd9;
`ifdef SEG_READER_HEX_EN
                7'h77: dec_digit = 4'd10;
                7'h7c: dec_digit = 4'd11;
                7'h39: dec_digit = 4'd12;
                7'h5e: dec_digit = 4'd13;
                7'h79: dec_digit = 4'd14;
                7'h71: dec_digit = 4'd15;
`else
`endif
                default: dec_err = 1'b1;
            endcase
        end
    end

    // A fresh result always wins over the handshake; overwriting an unaccepted one is flagged.
    always_comb begin
        valid_d = valid_q;
        digit_d = digit_q;
        dp_d    = dp_q;
        blank_d = blank_q;
        err_d   = err_q;
        ovr_d   = ovr_q;
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        if (ld) begin
            valid_d = 1'b1;
            digit_d = dec_digit;
            dp_d    = s_q[7];
            blank_d = dec_blank;
            err_d   = dec_err;
            if (valid_q && !out_ready) begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= 9'd0;
            cnt_q   <= 8'd0;
            valid_q <= 1'b0;
            digit_q <= 4'd0;
            dp_q    <= 1'b0;
            blank_q <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            digit_q <= digit_d;
            dp_q    <= dp_d;
            blank_q <= blank_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out_valid = valid_q;
    assign out_digit = digit_q;
    assign out_dp    = dp_q;
    assign out_blank = blank_q;
    assign out_err   = err_q;
    assign overrun   = ovr_q;

endmodule
